wb_timer: RTL

Wishbone classic-cycle responder implementing a 32-bit prescaled timer with compare match, auto-reload and a level interrupt. It sits on the external Wishbone bus driven by the SoC's OBI-to-Wishbone bridge, alongside the I2C and pinmux responders, and is the first timer peripheral reachable from CV32E40X firmware.

---
 rtl/wb_timer_if.sv | 20 ++
 rtl/wb_timer.sv | 130 +++++++++++++
 2 files changed

// File: rtl/wb_timer_if.sv
// Wishbone classic-cycle bundle between the bus bridge (master) and the timer
// responder (slave).
interface wb_timer_if #(
  parameter int ADDR_WIDTH = 32
);
  // Handshake: a request is cyc & stb held by the master; the slave answers with a
  // single-cycle ack, after which the master drops stb. rdata is meaningful only
  // while ack is high.
  logic [ADDR_WIDTH-1:0] addr;
  logic [31:0]           wdata;
  logic [31:0]           rdata;
  logic                  wr_en;
  logic [3:0]            byte_en;
  logic                  stb;
  logic                  cyc;
  logic                  ack;

  modport master (output addr, wdata, wr_en, byte_en, stb, cyc, input rdata, ack);
  modport slave  (input addr, wdata, wr_en, byte_en, stb, cyc, output rdata, ack);
endinterface

// File: rtl/wb_timer.sv
// 32-bit prescaled timer on Wishbone: compare match, optional auto-reload,
// sticky write-1-to-clear MATCH flag and a registered level interrupt.
module wb_timer #(
  parameter logic [7:0] SEL_BYTE   = 8'h0D,
  parameter int         ADDR_WIDTH = 32
) (
  input  logic      clk_i,
  input  logic      rst_ni,
  wb_timer_if.slave wb,
  output logic      irq_o
);
  localparam logic [2:0] IDX_CTRL     = 3'd0;
  localparam logic [2:0] IDX_PRESCALE = 3'd1;
  localparam logic [2:0] IDX_COUNT    = 3'd2;
  localparam logic [2:0] IDX_COMPARE  = 3'd3;
  localparam logic [2:0] IDX_STATUS   = 3'd4;

  logic        ack_q;
  logic [31:0] rdata_q;
  logic        irq_q, irq_d;
  logic [2:0]  ctrl_q, ctrl_d;
  logic [15:0] prescale_q, prescale_d;
  logic [15:0] pcnt_q, pcnt_d;
  logic [31:0] count_q, count_d;
  logic [31:0] compare_q, compare_d;
  logic        match_q, match_d;

  logic        req, access, wr, rd;
  logic [2:0]  idx;
  logic        tick, hit;
  logic [31:0] rd_mux;
  logic        unused_addr;

  function automatic logic [31:0] merge_be(input logic [31:0] old_v,
                                           input logic [31:0] new_v,
                                           input logic [3:0]  be);
    logic [31:0] res;
    for (int b = 0; b < 4; b++) begin
      res[8*b +: 8] = be[b] ? new_v[8*b +: 8] : old_v[8*b +: 8];
    end
    return res;
  endfunction

  // A request is acted on only in the cycle before its ack, so a held strobe
  // produces one access every second cycle.
  assign req    = wb.cyc & wb.stb & (wb.addr[ADDR_WIDTH-1 -: 8] == SEL_BYTE);
  assign access = req & ~ack_q;
  assign wr     = access & wb.wr_en;
  assign rd     = access & ~wb.wr_en;
  assign idx    = wb.addr[4:2];
  assign tick   = ctrl_q[0] & (pcnt_q == prescale_q);
  assign hit    = tick & (count_q == compare_q);

  assign unused_addr = ^{wb.addr[ADDR_WIDTH-9:5], wb.addr[1:0]};

  always_comb begin
    rd_mux = '0;
    case (idx)
      IDX_CTRL:     rd_mux = {29'd0, ctrl_q};
      IDX_PRESCALE: rd_mux = {16'd0, prescale_q};
      IDX_COUNT:    rd_mux = count_q;
      IDX_COMPARE:  rd_mux = compare_q;
      IDX_STATUS:   rd_mux = {31'd0, match_q};
      default:      rd_mux = '0;
    endcase
  end

  always_comb begin
    ctrl_d     = ctrl_q;
    prescale_d = prescale_q;
    count_d    = count_q;
    compare_d  = compare_q;
    match_d    = match_q;
    pcnt_d     = '0;

    if (ctrl_q[0] && !tick) pcnt_d = pcnt_q + 16'd1;
    if (tick) count_d = (hit && ctrl_q[1]) ? 32'd0 : count_q + 32'd1;

    // Bus writes are applied after the tick so a COUNT write overrides it.
    if (wr) begin
      case (idx)
        IDX_CTRL: begin
          if (wb.byte_en[0]) ctrl_d = wb.wdata[2:0];
          pcnt_d = '0;
        end
        IDX_PRESCALE: begin
          if (wb.byte_en[0]) prescale_d[7:0]  = wb.wdata[7:0];
          if (wb.byte_en[1]) prescale_d[15:8] = wb.wdata[15:8];
          pcnt_d = '0;
        end
        IDX_COUNT:   count_d   = merge_be(count_q, wb.wdata, wb.byte_en);
        IDX_COMPARE: compare_d = merge_be(compare_q, wb.wdata, wb.byte_en);
        IDX_STATUS:  if (wb.byte_en[0] && wb.wdata[0]) match_d = 1'b0;
        default: ;
      endcase
    end

    // A fresh match outranks a simultaneous clear.
    if (hit) match_d = 1'b1;
    irq_d = match_d & ctrl_d[2];
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ack_q      <= 1'b0;
      rdata_q    <= '0;
      irq_q      <= 1'b0;
      ctrl_q     <= '0;
      prescale_q <= '0;
      pcnt_q     <= '0;
      count_q    <= '0;
      compare_q  <= 32'hFFFF_FFFF;
      match_q    <= 1'b0;
    end else begin
      ack_q      <= access;
      rdata_q    <= rd ? rd_mux : 32'd0;
      irq_q      <= irq_d;
      ctrl_q     <= ctrl_d;
      prescale_q <= prescale_d;
      pcnt_q     <= pcnt_d;
      count_q    <= count_d;
      compare_q  <= compare_d;
      match_q    <= match_d;
    end
  end

  assign wb.ack   = ack_q;
  assign wb.rdata = rdata_q;
  assign irq_o    = irq_q;
endmodule
